// File: rtl/amba_mem_io_slave_if.sv
// -----------------------------------------------------------------------------
// amba_mem_io_slave_if
// Single-beat AXI-lite style bus between the CPU memory master and the
// memory/IO responder.
//   AR channel : ARAddr, ARValid (master) / ARReady (slave)
//   R  channel : RData, RValid, RResp (slave) / RReady (master)
//   AW channel : AWAddr, AWValid (master) / AWReady (slave)
//   W  channel : WData, WValid (master) / WReady (slave)
//   B  channel : BResp, BValid (slave) / BReady (master)
// -----------------------------------------------------------------------------
interface amba_mem_io_slave_if;
    logic [31:0] ARAddr;
    logic        ARValid;
    logic        ARReady;
    logic [31:0] RData;
    logic        RValid;
    logic        RResp;
    logic        RReady;
    logic [31:0] AWAddr;
    logic        AWValid;
    logic        AWReady;
    logic [31:0] WData;
    logic        WValid;
    logic        WReady;
    logic        BResp;
    logic        BValid;
    logic        BReady;

    modport slave (
        input  ARAddr, ARValid, RReady, AWAddr, AWValid, WData, WValid, BReady,
        output ARReady, RData, RValid, RResp, AWReady, WReady, BResp, BValid
    );

    modport master (
        output ARAddr, ARValid, RReady, AWAddr, AWValid, WData, WValid, BReady,
        input  ARReady, RData, RValid, RResp, AWReady, WReady, BResp, BValid
    );
endinterface

// File: rtl/amba_mem_io_slave.sv
// -----------------------------------------------------------------------------
// amba_mem_io_slave
// Responder for single-beat reads and writes: a word RAM at byte addresses
// 0 .. 4*MEM_WORDS-1, a read-only switch register at IO_BASE and an LED
// register at IO_BASE+4. One transaction per channel in flight.
//   Aclk    : bus clock, rising edge
//   Aresetn : asynchronous active-low reset
//   bus     : AR/R/AW/W/B channels (slave modport)
//   SW      : board switches, asynchronous to Aclk
//   LED     : board LEDs, registered
// -----------------------------------------------------------------------------
module amba_mem_io_slave #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic                      Aclk,
    input  logic                      Aresetn,
    amba_mem_io_slave_if.slave        bus,
    input  logic [31:0]               SW,
    output logic [31:0]               LED
);

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [31:0] LED_ADDR  = IO_BASE + 32'd4;

    typedef enum logic [1:0] {T_RAM, T_SW, T_LED, T_NONE} target_e;
    typedef enum logic       {R_IDLE, R_DATA}             r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP}     w_state_e;

    // Address bits [1:0] never take part in decode.
    function automatic target_e decode(input logic [31:0] addr);
        if (addr < RAM_BYTES)                 return T_RAM;
        else if (addr[31:2] == IO_BASE[31:2]) return T_SW;
        else if (addr[31:2] == LED_ADDR[31:2]) return T_LED;
        else                                  return T_NONE;
    endfunction

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] sw_meta, sw_sync;
    logic        run;

    // ---------------------------------------------------------------- misc
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, regardless of block order.
    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) begin
            run     <= 1'b0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            run     <= 1'b1;      // readies come up one edge after reset release
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    // ---------------------------------------------------------------- read
    r_state_e    r_state, r_next;
    logic        ar_hs;
    logic [31:0] rdata_q;
    logic        rresp_q;
    target_e     rd_tgt;

    assign rd_tgt = decode(bus.ARAddr);

    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // NOTE: every output of a combinational block gets a default first,
    // otherwise unassigned paths infer latches.
    always_comb begin
        r_next      = r_state;
        bus.ARReady = 1'b0;
        bus.RValid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.ARReady = run;
                if (bus.ARValid && run) r_next = R_DATA;
            end
            R_DATA: begin
                bus.RValid = 1'b1;
                if (bus.RReady) r_next = R_IDLE;
            end
        endcase
    end

    assign ar_hs = bus.ARValid && bus.ARReady;

    // Read data is captured at the address handshake, so a write committed
    // on the same edge is not yet visible.
    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) begin
            rdata_q <= '0;
            rresp_q <= 1'b0;
        end else if (ar_hs) begin
            rresp_q <= 1'b0;
            case (rd_tgt)
                T_RAM:   rdata_q <= mem[bus.ARAddr[IDX_W+1:2]];
                T_SW:    rdata_q <= sw_sync;
                T_LED:   rdata_q <= LED;
                default: begin
                    rdata_q <= '0;
                    rresp_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.RData = rdata_q;
    assign bus.RResp = rresp_q;

    // --------------------------------------------------------------- write
    w_state_e    w_state, w_next;
    logic        aw_got, w_got;
    logic        aw_hs, w_hs, commit;
    logic [31:0] aw_addr_q, w_data_q;
    logic [31:0] wr_addr, wr_data;
    logic        bresp_q;
    target_e     wr_tgt;

    // A channel handshaken this edge is used directly; one captured earlier
    // comes from its holding register.
    assign wr_addr = aw_got ? aw_addr_q : bus.AWAddr;
    assign wr_data = w_got  ? w_data_q  : bus.WData;
    assign wr_tgt  = decode(wr_addr);

    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        bus.AWReady = 1'b0;
        bus.WReady  = 1'b0;
        bus.BValid  = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        commit      = 1'b0;
        case (w_state)
            W_IDLE, W_WAIT: begin
                bus.AWReady = run && !aw_got;
                bus.WReady  = run && !w_got;
                aw_hs       = bus.AWValid && bus.AWReady;
                w_hs        = bus.WValid && bus.WReady;
                if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs || w_hs) begin
                    w_next = W_WAIT;
                end
            end
            W_RESP: begin
                bus.BValid = 1'b1;
                if (bus.BReady) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge Aclk or negedge Aresetn) begin
        if (!Aresetn) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            bresp_q   <= 1'b0;
            LED       <= '0;
        end else begin
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_q <= bus.AWAddr;
            end
            if (w_hs) begin
                w_got    <= 1'b1;
                w_data_q <= bus.WData;
            end
            if (commit) begin
                bresp_q <= (wr_tgt == T_SW) || (wr_tgt == T_NONE);
                if (wr_tgt == T_LED) LED <= wr_data;
            end
            if (bus.BValid && bus.BReady) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    // NOTE: the RAM array has no reset; contents are undefined at power-up
    // and committed words survive a bus reset.
    always_ff @(posedge Aclk) begin
        if (commit && wr_tgt == T_RAM) mem[wr_addr[IDX_W+1:2]] <= wr_data;
    end

    assign bus.BResp = bresp_q;

endmodule

// File: tb/tb_amba_mem_io_slave.sv
// -----------------------------------------------------------------------------
// tb_amba_mem_io_slave
// Table of directed read/write vectors, hand-written multi-cycle sequences,
// and randomized traffic checked against an address-map model.
// -----------------------------------------------------------------------------
module tb_amba_mem_io_slave;

    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] LED_ADDR  = IO_BASE + 32'd4;

    logic        Aclk = 1'b0;
    logic        Aresetn = 1'b0;
    logic [31:0] SW;
    logic [31:0] LED;

    amba_mem_io_slave_if bus();

    amba_mem_io_slave #(.MEM_WORDS(MEM_WORDS), .IO_BASE(IO_BASE)) dut (
        .Aclk    (Aclk),
        .Aresetn (Aresetn),
        .bus     (bus),
        .SW      (SW),
        .LED     (LED)
    );

    always #5 Aclk = ~Aclk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    logic [31:0] ram_m [int];
    logic [31:0] led_m = '0;
    logic [31:0] sw_m  = '0;

    function automatic logic model_write(input logic [31:0] a, input logic [31:0] d);
        if (a < 32'(4 * MEM_WORDS)) begin
            ram_m[int'(a >> 2)] = d;
            return 1'b0;
        end
        if ((a >> 2) == (LED_ADDR >> 2)) begin
            led_m = d;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] d,
                              output bit known, output logic resp);
        known = 1'b1;
        resp  = 1'b0;
        d     = '0;
        if (a < 32'(4 * MEM_WORDS)) begin
            known = ram_m.exists(int'(a >> 2));
            if (known) d = ram_m[int'(a >> 2)];
        end else if ((a >> 2) == (IO_BASE >> 2)) begin
            d = sw_m;
        end else if ((a >> 2) == (LED_ADDR >> 2)) begin
            d = led_m;
        end else begin
            resp = 1'b1;
        end
    endtask

    // ---------------------------------------------------------- bus tasks
    // All tasks start and end just after a falling edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_now, w_now;
        int n = 0;
        resp = 1'bx;
        while (!(aw_done && w_done)) begin
            if (n > 50) begin
                check("write_handshake_timeout", 32'd0, 32'd1);
                bus.AWValid = 1'b0;
                bus.WValid  = 1'b0;
                return;
            end
            bus.AWAddr  = a;
            bus.WData   = d;
            bus.AWValid = !aw_done && n >= aw_dly;
            bus.WValid  = !w_done && n >= w_dly;
            if (aw_done && !w_done) check("awready_after_capture", bus.AWReady, 0);
            if (w_done && !aw_done) check("wready_after_capture", bus.WReady, 0);
            aw_now = bus.AWValid && bus.AWReady;
            w_now  = bus.WValid && bus.WReady;
            @(posedge Aclk);
            @(negedge Aclk);
            aw_done = aw_done || aw_now;
            w_done  = w_done || w_now;
            n++;
        end
        bus.AWValid = 1'b0;
        bus.WValid  = 1'b0;
        check("bvalid_next_cycle", bus.BValid, 1);
        for (int i = 0; i < b_dly; i++) begin
            bus.BReady = 1'b0;
            @(posedge Aclk);
            @(negedge Aclk);
            check("bvalid_held", bus.BValid, 1);
        end
        resp = bus.BResp;
        bus.BReady = 1'b1;
        @(posedge Aclk);
        @(negedge Aclk);
        bus.BReady = 1'b0;
        check("bvalid_drop", bus.BValid, 0);
        check("wr_readies_restored", {bus.AWReady, bus.WReady}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_dly,
                            output logic [31:0] data, output logic resp);
        bit done = 1'b0;
        int n = 0;
        data = 'x;
        resp = 1'bx;
        while (!done) begin
            if (n > 50) begin
                check("read_handshake_timeout", 32'd0, 32'd1);
                bus.ARValid = 1'b0;
                return;
            end
            bus.ARAddr  = a;
            bus.ARValid = 1'b1;
            done = bus.ARReady;
            @(posedge Aclk);
            @(negedge Aclk);
            n++;
        end
        bus.ARValid = 1'b0;
        check("rvalid_next_cycle", bus.RValid, 1);
        check("arready_low_in_data", bus.ARReady, 0);
        data = bus.RData;
        resp = bus.RResp;
        for (int i = 0; i < r_dly; i++) begin
            bus.RReady = 1'b0;
            @(posedge Aclk);
            @(negedge Aclk);
            check("rvalid_held", bus.RValid, 1);
            check("rdata_stable", {bus.RResp, bus.RData}, {resp, data});
            check("arready_held_low", bus.ARReady, 0);
        end
        bus.RReady = 1'b1;
        @(posedge Aclk);
        @(negedge Aclk);
        bus.RReady = 1'b0;
        check("rvalid_drop", bus.RValid, 0);
        check("arready_restored", bus.ARReady, 1);
    endtask

    // ---------------------------------------------------------- vectors
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_resp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] rd;
        logic        rs;
        logic [31:0] exp_d;
        bit          known;
        logic        exp_r;

        tbl.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b1, LED_ADDR,      32'h0000_00A5, 32'h0,         1'b0});
        tbl.push_back('{1'b0, LED_ADDR,      32'h0,         32'h0000_00A5, 1'b0});
        tbl.push_back('{1'b1, IO_BASE + 8,   32'h0000_FFFF, 32'h0,         1'b1});
        tbl.push_back('{1'b0, IO_BASE,       32'h0,         32'h0BAD_F00D, 1'b0});
        tbl.push_back('{1'b1, IO_BASE,       32'h0000_0055, 32'h0,         1'b1});
        tbl.push_back('{1'b0, IO_BASE,       32'h0,         32'h0BAD_F00D, 1'b0});
        tbl.push_back('{1'b0, LED_ADDR,      32'h0,         32'h0000_00A5, 1'b0});

        // -------------------------------------------------------- reset
        bus.ARAddr = '0; bus.AWAddr = '0; bus.WData = '0;
        bus.ARValid = 1'b1; bus.AWValid = 1'b1; bus.WValid = 1'b1;
        bus.RReady = 1'b0; bus.BReady = 1'b0;
        SW   = 32'h0BAD_F00D;
        sw_m = 32'h0BAD_F00D;
        repeat (3) @(posedge Aclk);
        @(negedge Aclk);
        check("rst_readies", {bus.ARReady, bus.AWReady, bus.WReady}, 3'b000);
        check("rst_valids", {bus.RValid, bus.BValid}, 2'b00);
        check("rst_resps_rdata", {bus.RResp, bus.BResp, bus.RData}, 34'h0);
        check("rst_led", LED, 32'h0);
        bus.ARValid = 1'b0; bus.AWValid = 1'b0; bus.WValid = 1'b0;
        Aresetn = 1'b1;
        check("readies_before_first_edge", {bus.ARReady, bus.AWReady, bus.WReady}, 3'b000);
        @(posedge Aclk);
        #1;
        check("readies_after_first_edge", {bus.ARReady, bus.AWReady, bus.WReady}, 3'b111);
        @(negedge Aclk);

        // -------------------------------------------------------- table
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, 0, 0, 0, rs);
                void'(model_write(tbl[i].addr, tbl[i].data));
                check($sformatf("tbl%0d_bresp", i), rs, tbl[i].exp_resp);
            end else begin
                axi_read(tbl[i].addr, 0, rd, rs);
                check($sformatf("tbl%0d_rresp", i), rs, tbl[i].exp_resp);
                check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_data);
            end
        end

        // ------------------------------------------ W before AW to LED
        axi_write(LED_ADDR, 32'h0000_005A, 3, 0, 0, rs);
        void'(model_write(LED_ADDR, 32'h0000_005A));
        check("w_first_bresp", rs, 0);
        check("w_first_led", LED, 32'h0000_005A);
        // AW before W, with a stalled B channel
        axi_write(32'h0000_0040, 32'h0F0F_0F0F, 0, 2, 3, rs);
        void'(model_write(32'h0000_0040, 32'h0F0F_0F0F));
        check("aw_first_bresp", rs, 0);

        // ------------------------------------------ R channel back-pressure
        axi_read(32'h0000_0040, 5, rd, rs);
        check("rstall_rdata", rd, 32'h0F0F_0F0F);
        check("rstall_rresp", rs, 0);

        // ------------------------------------------ SW synchronizer
        SW   = 32'h0000_1234;
        sw_m = 32'h0000_1234;
        repeat (3) @(posedge Aclk);
        @(negedge Aclk);
        axi_read(IO_BASE, 0, rd, rs);
        check("sw_sync_read", rd, 32'h0000_1234);

        // ------------------------------------------ same-edge read + write
        axi_write(32'h0000_0020, 32'h1111_1111, 0, 0, 0, rs);
        void'(model_write(32'h0000_0020, 32'h1111_1111));
        bus.ARAddr = 32'h20; bus.ARValid = 1'b1;
        bus.AWAddr = 32'h20; bus.AWValid = 1'b1;
        bus.WData  = 32'h2222_2222; bus.WValid = 1'b1;
        check("same_edge_readies", {bus.ARReady, bus.AWReady, bus.WReady}, 3'b111);
        @(posedge Aclk);
        @(negedge Aclk);
        bus.ARValid = 1'b0; bus.AWValid = 1'b0; bus.WValid = 1'b0;
        check("same_edge_valids", {bus.RValid, bus.BValid}, 2'b11);
        check("same_edge_old_data", bus.RData, 32'h1111_1111);
        check("same_edge_bresp", bus.BResp, 0);
        bus.RReady = 1'b1; bus.BReady = 1'b1;
        @(posedge Aclk);
        @(negedge Aclk);
        bus.RReady = 1'b0; bus.BReady = 1'b0;
        void'(model_write(32'h0000_0020, 32'h2222_2222));
        axi_read(32'h0000_0020, 0, rd, rs);
        check("same_edge_new_data", rd, 32'h2222_2222);

        // ------------------------------------------ randomized traffic
        for (int it = 0; it < 150; it++) begin
            logic [31:0] a, d;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)
                a = ($urandom_range(0, 4) == 0) ? (32'h3FC | 32'($urandom_range(0, 3)))
                                                : 32'($urandom_range(0, 63));
            else if (sel == 6) a = IO_BASE;
            else if (sel == 7) a = LED_ADDR;
            else if (sel == 8) a = 32'h400 + 32'($urandom_range(0, 255));
            else               a = 32'h1000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), rs);
                exp_r = model_write(a, d);
                check($sformatf("rnd%0d_bresp@%h", it, a), rs, exp_r);
            end else begin
                axi_read(a, int'($urandom_range(0, 3)), rd, rs);
                model_read(a, exp_d, known, exp_r);
                check($sformatf("rnd%0d_rresp@%h", it, a), rs, exp_r);
                if (known) check($sformatf("rnd%0d_rdata@%h", it, a), rd, exp_d);
            end
        end
        check("rnd_led", LED, led_m);

        // ------------------------------------------ reset mid-transaction
        bus.AWAddr = LED_ADDR; bus.AWValid = 1'b1;
        bus.WData  = 32'h0000_0077; bus.WValid = 1'b1;
        @(posedge Aclk);
        @(negedge Aclk);
        bus.AWValid = 1'b0; bus.WValid = 1'b0;
        check("midrst_bvalid_pending", bus.BValid, 1);
        check("midrst_led_written", LED, 32'h0000_0077);
        Aresetn = 1'b0;
        #1;
        check("midrst_bvalid_cleared", bus.BValid, 0);
        check("midrst_led_cleared", LED, 32'h0);
        check("midrst_readies", {bus.ARReady, bus.AWReady, bus.WReady}, 3'b000);
        led_m = '0;
        @(negedge Aclk);
        Aresetn = 1'b1;
        @(negedge Aclk);
        check("postrst_readies", {bus.ARReady, bus.AWReady, bus.WReady}, 3'b111);
        check("postrst_bvalid", bus.BValid, 0);
        axi_read(32'h0000_0010, 0, rd, rs);
        model_read(32'h0000_0010, exp_d, known, exp_r);
        check("postrst_ram_kept", rd, exp_d);
        axi_read(LED_ADDR, 0, rd, rs);
        check("postrst_led_read", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
